// File: rtl/ca_pkg.sv
// Shared types and default sizes for the elementary cellular automaton run controller.
package ca_pkg;

  localparam int CA_WIDTH = 20;
  localparam int CA_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

endpackage

// File: rtl/ca_step.sv
// One generation of an elementary cellular automaton on a periodic ring.
// Cell i looks at {right neighbour i+1, itself, left neighbour i-1}; that
// 3-bit value selects a bit of the Wolfram rule.
module ca_step
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH
) (
  input  logic [7:0]       rule,
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] nxt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    // Neighbour indices wrap around the ring ends.
    localparam int IDX_HI = (i + 1) % WIDTH;
    localparam int IDX_LO = (i + WIDTH - 1) % WIDTH;

    assign nxt[i] = rule[{state[IDX_HI], state[i], state[IDX_LO]}];
  end

endmodule

// File: rtl/ca_run_ctrl.sv
// Run controller: accepts a rule/pattern/count, advances one generation per
// clock (pausable), stops early on a fixed point and pulses done at the end.
module ca_run_ctrl
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH,
  parameter int CNT_W = CA_CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [7:0]       rule,
  input  logic [WIDTH-1:0] init,
  input  logic [CNT_W-1:0] gens,
  input  logic             hold,
  output logic [WIDTH-1:0] state,
  output logic [CNT_W-1:0] gen_cnt,
  output logic             busy,
  output logic             done,
  output logic             stable
);

  fsm_t             fsm_q, fsm_d;
  logic [7:0]       rule_q, rule_d;
  logic [CNT_W-1:0] gens_q, gens_d;
  logic [WIDTH-1:0] state_d;
  logic [CNT_W-1:0] gen_cnt_d;
  logic             stable_d;
  logic [WIDTH-1:0] step_nxt;
  logic [CNT_W-1:0] gen_cnt_inc;

  ca_step #(.WIDTH(WIDTH)) u_step (
    .rule  (rule_q),
    .state (state),
    .nxt   (step_nxt)
  );

  // gen_cnt never exceeds gens_q - 1 while running, so this cannot wrap.
  assign gen_cnt_inc = gen_cnt + CNT_W'(1);

  // Next-state and next-register decode for the run FSM.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    fsm_d     = fsm_q;
    rule_d    = rule_q;
    gens_d    = gens_q;
    state_d   = state;
    gen_cnt_d = gen_cnt;
    stable_d  = stable;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          rule_d    = rule;
          gens_d    = gens;
          state_d   = init;
          gen_cnt_d = '0;
          stable_d  = 1'b0;
          fsm_d     = (gens != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          state_d   = step_nxt;
          gen_cnt_d = gen_cnt_inc;
          // A fixed point wins over reaching the requested count.
          if (step_nxt == state) begin
            stable_d = 1'b1;
            fsm_d    = ST_DONE;
          end else if (gen_cnt_inc == gens_q) begin
            fsm_d = ST_DONE;
          end
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; busy/done are registered decodes of the next FSM state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fsm_q   <= ST_IDLE;
      rule_q  <= '0;
      gens_q  <= '0;
      state   <= '0;
      gen_cnt <= '0;
      stable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fsm_q   <= fsm_d;
      rule_q  <= rule_d;
      gens_q  <= gens_d;
      state   <= state_d;
      gen_cnt <= gen_cnt_d;
      stable  <= stable_d;
      busy    <= (fsm_d != ST_IDLE);
      done    <= (fsm_d == ST_DONE);
    end
  end

endmodule
